// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Optional build macro: DMEM_ARB_CPU_PRIO_EN (fixed CPU priority instead of round-robin).
package dmem_arb_pkg;

    localparam int unsigned DEFAULT_DW        = 8;
    localparam int unsigned DEFAULT_AW        = 6;
    localparam int unsigned DEFAULT_MAX_BURST = 4;

    // Port identifiers, also the encoding of last_owner and the picker winner
    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_IO  = 1'b1;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StGntCpu = 2'd1,
        StGntIo  = 2'd2
    } arb_state_e;

    // Grant state that serves the given port
    function automatic arb_state_e grant_state(input logic port);
        return (port == PORT_IO) ? StGntIo : StGntCpu;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side req/gnt handshake bundle; one instance per arbiter port.
// master = requester (CPU or I/O block), slave = arbiter.
interface dmem_arbiter_if #(
    parameter int unsigned DW = dmem_arb_pkg::DEFAULT_DW,
    parameter int unsigned AW = dmem_arb_pkg::DEFAULT_AW
) ();

    logic          req;
    logic          we;
    logic          lock;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    logic          gnt;
    logic          rvalid;
    logic [DW-1:0] rdata;

    modport master (
        output req, we, lock, addr, wd,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, lock, addr, wd,
        output gnt, rvalid, rdata
    );

endinterface

// File: rtl/rr_pick2.sv
// Combinational two-way picker for the data-memory arbiter.
// Default: round-robin, a tie goes to the port that is not last_owner.
// DMEM_ARB_CPU_PRIO_EN defined: CPU always wins a tie, last_owner is ignored.
module rr_pick2 import dmem_arb_pkg::*; (
    input  logic req_cpu,
    input  logic req_io,
    input  logic last_owner,
    output logic winner,
    output logic valid
);

    assign valid = req_cpu | req_io;

`ifdef DMEM_ARB_CPU_PRIO_EN
    logic unused_last_owner;
    assign unused_last_owner = last_owner;

    // Fixed priority: the CPU wins whenever it asks
    always_comb begin
        winner = req_cpu ? PORT_CPU : PORT_IO;
    end
`else
    // Round-robin: single requester wins, tie goes away from last_owner
    always_comb begin
        winner = PORT_CPU;
        if (req_cpu && req_io) begin
            winner = (last_owner == PORT_CPU) ? PORT_IO : PORT_CPU;
        end else if (req_io) begin
            winner = PORT_IO;
        end
    end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU and the I/O requester.
// Registered grants, optional locked bursts of up to MAX_BURST accesses, read data
// returned one cycle after the transfer edge.
// Build macro DMEM_ARB_CPU_PRIO_EN selects fixed CPU priority (default: round-robin).
module dmem_arbiter import dmem_arb_pkg::*; #(
    parameter int unsigned DW        = DEFAULT_DW,
    parameter int unsigned AW        = DEFAULT_AW,
    parameter int unsigned MAX_BURST = DEFAULT_MAX_BURST
) (
    input  logic            clk,
    input  logic            reset,
    dmem_arbiter_if.slave   cpu,
    dmem_arbiter_if.slave   io,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wd,
    input  logic [DW-1:0]   mem_rd
);

    localparam int unsigned BurstW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    // Highest burst index; a locked owner may stay only while below it
    localparam logic [BurstW-1:0] BurstLast = BurstW'(MAX_BURST - 1);

    arb_state_e        state_q, state_d;
    logic [BurstW-1:0] burst_cnt_q, burst_cnt_d;
    logic              last_owner_q, last_owner_d;
    logic              cpu_rvalid_q, cpu_rvalid_d;
    logic [DW-1:0]     cpu_rdata_q, cpu_rdata_d;
    logic              io_rvalid_q, io_rvalid_d;
    logic [DW-1:0]     io_rdata_q, io_rdata_d;

    logic              pick_last;
    logic              pick_winner;
    logic              pick_valid;

    // In a grant state the current owner counts as last owner for the exit decision
    assign pick_last = (state_q == StGntCpu) ? PORT_CPU :
                       (state_q == StGntIo)  ? PORT_IO  : last_owner_q;

    rr_pick2 u_pick (
        .req_cpu    (cpu.req),
        .req_io     (io.req),
        .last_owner (pick_last),
        .winner     (pick_winner),
        .valid      (pick_valid)
    );

    assign cpu.gnt    = (state_q == StGntCpu);
    assign io.gnt     = (state_q == StGntIo);
    assign cpu.rvalid = cpu_rvalid_q;
    assign cpu.rdata  = cpu_rdata_q;
    assign io.rvalid  = io_rvalid_q;
    assign io.rdata   = io_rdata_q;

    // Next-state: grant decision, burst counting, read-data capture
    always_comb begin
        state_d      = state_q;
        burst_cnt_d  = burst_cnt_q;
        last_owner_d = last_owner_q;
        cpu_rvalid_d = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        io_rvalid_d  = 1'b0;
        io_rdata_d   = io_rdata_q;

        unique case (state_q)
            StIdle: begin
                burst_cnt_d = '0;
                if (pick_valid) begin
                    state_d = grant_state(pick_winner);
                end
            end
            StGntCpu: begin
                last_owner_d = PORT_CPU;
                if (cpu.req && !cpu.we) begin
                    cpu_rvalid_d = 1'b1;
                    cpu_rdata_d  = mem_rd;
                end
                // lock only counts while the owner is actually requesting
                if (cpu.req && cpu.lock && (burst_cnt_q < BurstLast)) begin
                    burst_cnt_d = burst_cnt_q + BurstW'(1);
                end else begin
                    burst_cnt_d = '0;
                    state_d     = io.req ? grant_state(pick_winner) : StIdle;
                end
            end
            StGntIo: begin
                last_owner_d = PORT_IO;
                if (io.req && !io.we) begin
                    io_rvalid_d = 1'b1;
                    io_rdata_d  = mem_rd;
                end
                if (io.req && io.lock && (burst_cnt_q < BurstLast)) begin
                    burst_cnt_d = burst_cnt_q + BurstW'(1);
                end else begin
                    burst_cnt_d = '0;
                    state_d     = cpu.req ? grant_state(pick_winner) : StIdle;
                end
            end
            default: begin
                state_d     = StIdle;
                burst_cnt_d = '0;
            end
        endcase
    end

    // State and response registers, asynchronous active-high reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            burst_cnt_q  <= '0;
            last_owner_q <= PORT_IO;
            cpu_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
            io_rvalid_q  <= 1'b0;
            io_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            burst_cnt_q  <= burst_cnt_d;
            last_owner_q <= last_owner_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            cpu_rdata_q  <= cpu_rdata_d;
            io_rvalid_q  <= io_rvalid_d;
            io_rdata_q   <= io_rdata_d;
        end
    end

    // Memory mux; reset forces the bus quiet so an aborted write never commits
    always_comb begin
        mem_we   = 1'b0;
        mem_addr = cpu.addr;
        mem_wd   = cpu.wd;
        if (state_q == StGntIo) begin
            mem_addr = io.addr;
            mem_wd   = io.wd;
            mem_we   = io.req & io.we;
        end else if (state_q == StGntCpu) begin
            mem_we   = cpu.req & cpu.we;
        end
        if (reset) begin
            mem_we   = 1'b0;
            mem_addr = '0;
            mem_wd   = '0;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 64x8 memory.
// Inputs change just after the falling edge; outputs are sampled on the falling edge.
module tb_dmem_arbiter;

    localparam int DW = 8;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          tb_load = 1'b1;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wd;
    logic [DW-1:0] mem_rd;
    logic [DW-1:0] mem [64];

    int n_vec = 0;
    int n_err = 0;
    int cpu_viol = 0;
    int io_viol = 0;
    logic cpu_pend = 1'b0;
    logic io_pend = 1'b0;

    dmem_arbiter_if #(.DW(DW), .AW(AW)) cpu_if ();
    dmem_arbiter_if #(.DW(DW), .AW(AW)) io_if ();

    dmem_arbiter #(.DW(DW), .AW(AW), .MAX_BURST(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .cpu      (cpu_if),
        .io       (io_if),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wd   (mem_wd),
        .mem_rd   (mem_rd)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_val(input int a);
        if (a == 5) return 8'h3C;
        return 8'(a * 7 + 3);
    endfunction

    assign mem_rd = mem[mem_addr];

    always @(posedge clk) begin
        if (tb_load) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_val(i);
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wd;
        end
    end

    // Requester protocol watch: req must stay up until its transfer edge
    always @(posedge clk) begin
        if (reset) begin
            cpu_pend <= 1'b0;
            io_pend  <= 1'b0;
        end else begin
            if (cpu_pend && !cpu_if.req) cpu_viol <= cpu_viol + 1;
            if (io_pend && !io_if.req) io_viol <= io_viol + 1;
            cpu_pend <= cpu_if.req && !cpu_if.gnt;
            io_pend  <= io_if.req && !io_if.gnt;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        cpu_if.req = 1'b0; cpu_if.we = 1'b0; cpu_if.lock = 1'b0;
        cpu_if.addr = '0; cpu_if.wd = '0;
        io_if.req = 1'b0; io_if.we = 1'b0; io_if.lock = 1'b0;
        io_if.addr = '0; io_if.wd = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        logic [8:1] exp_io;
        logic [8:1] exp_cpu;
        logic       io_prev;
        int         k;

        idle_inputs();
        cpu_if.addr = 6'h2A;
        cpu_if.wd   = 8'h5A;
        repeat (2) tick();

        // Reset state, with non-zero CPU address/data on the inputs
        check_eq("rst_cpu_gnt", cpu_if.gnt, 0);
        check_eq("rst_io_gnt", io_if.gnt, 0);
        check_eq("rst_cpu_rvalid", cpu_if.rvalid, 0);
        check_eq("rst_io_rvalid", io_if.rvalid, 0);
        check_eq("rst_cpu_rdata", cpu_if.rdata, 0);
        check_eq("rst_io_rdata", io_if.rdata, 0);
        check_eq("rst_mem_we", mem_we, 0);
        check_eq("rst_mem_addr", mem_addr, 0);
        check_eq("rst_mem_wd", mem_wd, 0);
        reset = 1'b0;
        tb_load = 1'b0;
        idle_inputs();

        // Single CPU read of addr 5
        cpu_if.req = 1'b1; cpu_if.addr = 6'd5;
        tick();
        check_eq("rd_cpu_gnt", cpu_if.gnt, 1);
        check_eq("rd_io_gnt", io_if.gnt, 0);
        check_eq("rd_mem_addr", mem_addr, 5);
        check_eq("rd_mem_we", mem_we, 0);
        tick();
        check_eq("rd_cpu_rvalid", cpu_if.rvalid, 1);
        check_eq("rd_cpu_rdata", cpu_if.rdata, 8'h3C);
        check_eq("rd_cpu_gnt_off", cpu_if.gnt, 0);
        check_eq("rd_io_gnt_off", io_if.gnt, 0);
        cpu_if.req = 1'b0;
        tick();
        check_eq("rd_rvalid_pulse", cpu_if.rvalid, 0);

`ifndef DMEM_ARB_CPU_PRIO_EN
        // Simultaneous requests after reset: CPU first, then strict alternation
        reset = 1'b1;
        tick();
        reset = 1'b0;
        cpu_if.req = 1'b1; cpu_if.addr = 6'd1;
        io_if.req = 1'b1; io_if.addr = 6'd2;
        for (int c = 1; c <= 4; c++) begin
            tick();
            check_eq($sformatf("alt_cpu_gnt_c%0d", c), cpu_if.gnt, (c % 2) == 1);
            check_eq($sformatf("alt_io_gnt_c%0d", c), io_if.gnt, (c % 2) == 0);
            if (c == 2) begin
                check_eq("alt_cpu_rvalid", cpu_if.rvalid, 1);
                check_eq("alt_cpu_rdata", cpu_if.rdata, init_val(1));
            end
            if (c == 3) begin
                check_eq("alt_io_rvalid", io_if.rvalid, 1);
                check_eq("alt_io_rdata", io_if.rdata, init_val(2));
            end
            if (c == 4) cpu_if.req = 1'b0;
        end
        tick();
        check_eq("alt_end_io_gnt", io_if.gnt, 0);
        check_eq("alt_end_cpu_gnt", cpu_if.gnt, 0);
        check_eq("alt_end_io_rvalid", io_if.rvalid, 1);
        io_if.req = 1'b0;

        // Locked IO write burst of 6, CPU pending from cycle 1, MAX_BURST=4
        exp_io  = 8'b0110_1111;
        exp_cpu = 8'b0001_0000;
        io_if.req = 1'b1; io_if.we = 1'b1; io_if.lock = 1'b1;
        io_if.addr = 6'd10; io_if.wd = 8'h11;
        k = 0;
        io_prev = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            check_eq($sformatf("burst_io_gnt_c%0d", c), io_if.gnt, exp_io[c]);
            check_eq($sformatf("burst_cpu_gnt_c%0d", c), cpu_if.gnt, exp_cpu[c]);
            if (c == 1) begin
                check_eq("burst_mem_we", mem_we, 1);
                check_eq("burst_mem_addr", mem_addr, 10);
                check_eq("burst_mem_wd", mem_wd, 8'h11);
                cpu_if.req = 1'b1; cpu_if.we = 1'b0; cpu_if.addr = 6'd10;
            end
            if (c == 6) begin
                check_eq("burst_cpu_rvalid", cpu_if.rvalid, 1);
                check_eq("burst_cpu_rdata", cpu_if.rdata, 8'h11);
                cpu_if.req = 1'b0;
            end
            if (io_prev) k++;
            io_prev = io_if.gnt;
            if (k >= 6) begin
                io_if.req = 1'b0; io_if.we = 1'b0; io_if.lock = 1'b0;
            end else begin
                io_if.addr = 6'(10 + k);
                io_if.wd   = 8'(8'h11 + k);
                io_if.lock = (k < 5);
            end
        end
        for (int i = 0; i < 6; i++) begin
            check_eq($sformatf("burst_mem%0d", 10 + i), mem[10 + i], 8'(8'h11 + i));
        end
`endif

        // Locked CPU read, then req dropped while still granted
        idle_inputs();
        cpu_if.req = 1'b1; cpu_if.lock = 1'b1; cpu_if.addr = 6'd5;
        tick();
        check_eq("lkdrop_gnt1", cpu_if.gnt, 1);
        tick();
        check_eq("lkdrop_gnt2", cpu_if.gnt, 1);
        check_eq("lkdrop_rvalid1", cpu_if.rvalid, 1);
        check_eq("lkdrop_rdata1", cpu_if.rdata, 8'h3C);
        cpu_if.req = 1'b0; cpu_if.we = 1'b1; cpu_if.addr = 6'd21; cpu_if.wd = 8'h88;
        #1;
        check_eq("lkdrop_mem_we", mem_we, 0);
        tick();
        check_eq("lkdrop_cpu_gnt_off", cpu_if.gnt, 0);
        check_eq("lkdrop_io_gnt_off", io_if.gnt, 0);
        check_eq("lkdrop_rvalid2", cpu_if.rvalid, 0);
        check_eq("lkdrop_mem21", mem[21], init_val(21));
        idle_inputs();

        // Reset in the middle of a granted IO write
        io_if.req = 1'b1; io_if.we = 1'b1; io_if.addr = 6'd7; io_if.wd = 8'hAA;
        tick();
        check_eq("rstab_io_gnt", io_if.gnt, 1);
        check_eq("rstab_mem_we", mem_we, 1);
        #2;
        reset = 1'b1;
        #1;
        check_eq("rstab_io_gnt_off", io_if.gnt, 0);
        check_eq("rstab_cpu_gnt_off", cpu_if.gnt, 0);
        check_eq("rstab_mem_we_off", mem_we, 0);
        check_eq("rstab_io_rvalid", io_if.rvalid, 0);
        check_eq("rstab_cpu_rvalid", cpu_if.rvalid, 0);
        tick();
        idle_inputs();
        reset = 1'b0;
        tick();
        check_eq("rstab_mem7", mem[7], init_val(7));
        check_eq("rstab_idle_gnt", io_if.gnt, 0);
        check_eq("rstab_idle_rvalid", io_if.rvalid, 0);

`ifdef DMEM_ARB_CPU_PRIO_EN
        // Fixed priority: IO starves while the CPU keeps requesting
        cpu_if.req = 1'b1; cpu_if.addr = 6'd1;
        io_if.req = 1'b1; io_if.addr = 6'd2;
        for (int c = 1; c <= 7; c++) begin
            tick();
            check_eq($sformatf("prio_cpu_gnt_c%0d", c), cpu_if.gnt, 1);
            check_eq($sformatf("prio_io_gnt_c%0d", c), io_if.gnt, 0);
        end
        cpu_if.req = 1'b0;
        tick();
        check_eq("prio_io_gnt_after", io_if.gnt, 1);
        check_eq("prio_cpu_gnt_after", cpu_if.gnt, 0);
        tick();
        check_eq("prio_io_rvalid", io_if.rvalid, 1);
        check_eq("prio_io_rdata", io_if.rdata, init_val(2));
        io_if.req = 1'b0;
        tick();
`endif

        check_eq("protocol_violations", cpu_viol + io_viol, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-port 64x8 data memory between the CPU datapath and an I/O (DMA/peripheral) requester. Each requester uses a req/gnt handshake; the arbiter muxes the winner's address, write data and write enable onto the memory and returns read data one cycle later. It supports short locked bursts and round-robin fairness, and sits between the CPU core, the I/O block and the data memory.

## Interface
- DW, 8, data width
- AW, 6, memory address width
- MAX_BURST, 4, maximum consecutive accesses granted to one locked requester (≥1)

- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- cpu_req  in  1  CPU access request; held with cpu_we/addr/wd stable until transfer
- cpu_we  in  1  1 = write, 0 = read
- cpu_lock  in  1  CPU will request again the next cycle (burst)
- cpu_addr  in  AW  access address
- cpu_wd  in  DW  write data
- cpu_gnt  out  1  registered grant; transfer on an edge with cpu_req & cpu_gnt
- cpu_rvalid  out  1  one-cycle pulse, cpu_rdata valid
- cpu_rdata  out  DW  read data, registered
- io_req, io_we, io_lock, io_addr, io_wd, io_gnt, io_rvalid, io_rdata: same as the cpu_ set
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wd  out  DW  memory write data
- mem_rd  in  DW  memory combinational read data

## Operation
- FSM states: IDLE, GNT_CPU, GNT_IO. cpu_gnt = (state==GNT_CPU) and io_gnt = (state==GNT_IO). burst_cnt is 0..MAX_BURST-1. last_owner is 1 bit.
- IDLE: neither req → stay. One req → grant it. Both → grant the port that is not last_owner.
- Leaving GNT_x at the clock edge:
  - If lock_x and burst_cnt < MAX_BURST-1 → stay in GNT_x and increment burst_cnt.
  - Else if the other port's req is set → GNT_other, burst_cnt=0.
  - Else → IDLE, burst_cnt=0.
- last_owner is updated to x on every edge that ends a GNT_x cycle.
- Memory mux: in GNT_x, mem_addr=x_addr, mem_wd=x_wd and mem_we = x_req & x_we. In IDLE, mem_we=0 and mem_addr/mem_wd take the CPU values.
- Read: at the edge ending GNT_x with x_req & !x_we, capture mem_rd into x_rdata. x_rvalid=1 for the next cycle only.
- A write produces no rvalid.
- Locked grant with req dropped: gnt is high without req. There is no transfer, mem_we=0 and no rvalid. The burst ends under the normal exit rule. lock is ignored when req=0.
- A requester must not drop req before its transfer. This is a protocol violation, and the bench flags it.

## Timing
- Reset, asynchronously:
  - state=IDLE, burst_cnt=0, last_owner=IO so that the CPU wins the first tie.
  - All gnt=0, all rvalid=0, all rdata=0.
  - mem_we=0, mem_addr=0, mem_wd=0.
- Reset during an access aborts it: no write commits after reset is asserted, and no rvalid is issued.
- Latency from req (IDLE) to gnt: 1 cycle. From transfer edge to rvalid: 1 cycle.
- Throughput:
  - Unlocked, single requester: one access per 2 cycles (IDLE turnaround).
  - Locked: one access per cycle for up to MAX_BURST accesses.
  - Alternating requesters: one access per cycle with no IDLE gap.
- MAX_BURST=1: lock has no effect.

## Configuration
- DMEM_ARB_CPU_PRIO_EN defined: fixed priority. In IDLE, and at any exit with both ports requesting, the CPU wins. The IO port is served only when cpu_req=0 or during its own locked burst. last_owner is unused.
- Not defined: round-robin as described above.

## Structure
- Package dmem_arb_pkg:
  - state typedef (IDLE, GNT_CPU, GNT_IO).
  - Port-id constants PORT_CPU=0, PORT_IO=1.
  - Default width constants.
- Sub-module rr_pick2: combinational two-way picker taking req_cpu, req_io and last_owner, and returning a winner plus a valid flag. It is instantiated once, and its priority mode is selected by DMEM_ARB_CPU_PRIO_EN.

## Test plan
- Reset, then cpu_req read of addr 5 (mem holds 0x3C) → cpu_gnt in cycle 1, cpu_rvalid in cycle 2 with cpu_rdata=0x3C. io_gnt stays 0.
- cpu_req and io_req asserted together from IDLE after reset → CPU granted first, IO in the next cycle (no IDLE gap). Repeated simultaneous requests alternate CPU, IO, CPU, IO.
- io_lock=1 with io_req held for 6 write accesses of 0x11..0x16 to addr 10..15, MAX_BURST=4 → 4 consecutive io_gnt cycles, then release. A pending cpu_req is granted in cycle 5.
- Locked CPU drops cpu_req after the first transfer → second gnt cycle has mem_we=0 and no rvalid. State returns to IDLE.
- Reset asserted in a GNT_IO write cycle (io_wd=0xAA, addr 7) → addr 7 unchanged, all gnt/rvalid 0 at once, FSM in IDLE.
- With DMEM_ARB_CPU_PRIO_EN, cpu_req held continuously and io_req=1 → io_gnt never asserts. After cpu_req drops, io_gnt asserts within 1 cycle.
